// File: rtl/sysid_regfile.sv
// sysid_regfile: Avalon-MM system-identification slave.
// Returns the image ID, build timestamp, version and clock frequency.
// Provides a 64-bit cycle counter with a coherent high-word snapshot,
// a seconds uptime counter with clear/freeze control, and byte-enabled
// scratch registers. Reads have a fixed latency of one cycle.
module sysid_regfile #(
    parameter logic [31:0] ID_VALUE    = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP   = 32'h0000_0000,
    parameter logic [31:0] VERSION     = 32'h0001_0000,
    parameter logic [31:0] CLK_FREQ_HZ = 32'd50000000,
    parameter int          NUM_SCRATCH = 4,
    parameter int          ADDR_W      = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic [31:0]       readdata,
    output logic              readdatavalid
);

    localparam logic [31:0] PRE_TERM = CLK_FREQ_HZ - 32'd1;

    localparam logic [ADDR_W-1:0] A_ID     = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_TS     = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_VER    = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_FREQ   = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_UPTIME = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_CYC_LO = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] A_CYC_HI = ADDR_W'(6);
    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(7);

    logic [63:0] cyc_q, cyc_d;
    logic [31:0] hi_snap_q, hi_snap_d;
    logic [31:0] pre_q, pre_d;
    logic [31:0] up_q, up_d;
    logic        freeze_q, freeze_d;
    logic [31:0] scratch_q [NUM_SCRATCH];
    logic [31:0] scratch_d [NUM_SCRATCH];
    logic [31:0] rdata_q, rdata_d;
    logic        rvld_q, rvld_d;
    logic [31:0] rd_mux;
    logic        wr_ctrl;
    logic        clr_up;

    // CTRL writes only take effect when the low byte lane is enabled
    assign wr_ctrl = write && (address == A_CTRL) && byteenable[0];
    assign clr_up  = wr_ctrl && writedata[0];

    // Read multiplexer: current (pre-write) contents of the addressed word
    always_comb begin
        rd_mux = 32'd0;
        case (address)
            A_ID:     rd_mux = ID_VALUE;
            A_TS:     rd_mux = TIMESTAMP;
            A_VER:    rd_mux = VERSION;
            A_FREQ:   rd_mux = CLK_FREQ_HZ;
            A_UPTIME: rd_mux = up_q;
            A_CYC_LO: rd_mux = cyc_q[31:0];
            A_CYC_HI: rd_mux = hi_snap_q;
            A_CTRL:   rd_mux = {30'd0, freeze_q, 1'b0};
            default: begin
                for (int i = 0; i < NUM_SCRATCH; i++) begin
                    if (address == ADDR_W'(8 + i)) rd_mux = scratch_q[i];
                end
            end
        endcase
    end

    // Next-state for counters, control, snapshot, scratch and read port
    always_comb begin
        cyc_d     = cyc_q + 64'd1;
        hi_snap_d = (read && address == A_CYC_LO) ? cyc_q[63:32] : hi_snap_q;
        freeze_d  = wr_ctrl ? writedata[1] : freeze_q;
        pre_d     = pre_q;
        up_d      = up_q;
        // Clear beats both the terminal-count tick and a held counter
        if (clr_up) begin
            pre_d = 32'd0;
            up_d  = 32'd0;
        end else if (!freeze_q) begin
            if (pre_q == PRE_TERM) begin
                pre_d = 32'd0;
                up_d  = up_q + 32'd1;
            end else begin
                pre_d = pre_q + 32'd1;
            end
        end
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            scratch_d[i] = scratch_q[i];
            if (write && address == ADDR_W'(8 + i)) begin
                for (int b = 0; b < 4; b++) begin
                    if (byteenable[b]) scratch_d[i][8*b +: 8] = writedata[8*b +: 8];
                end
            end
        end
        rdata_d = read ? rd_mux : rdata_q;
        rvld_d  = read;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cyc_q     <= 64'd0;
            hi_snap_q <= 32'd0;
            pre_q     <= 32'd0;
            up_q      <= 32'd0;
            freeze_q  <= 1'b0;
            rdata_q   <= 32'd0;
            rvld_q    <= 1'b0;
            for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= 32'd0;
        end else begin
            cyc_q     <= cyc_d;
            hi_snap_q <= hi_snap_d;
            pre_q     <= pre_d;
            up_q      <= up_d;
            freeze_q  <= freeze_d;
            rdata_q   <= rdata_d;
            rvld_q    <= rvld_d;
            for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= scratch_d[i];
        end
    end

    assign readdata      = rdata_q;
    assign readdatavalid = rvld_q;

endmodule

// File: tb/tb_sysid_regfile.sv
// Testbench for sysid_regfile: directed scenarios plus randomized traffic
// checked against an abstract model (elapsed active cycles, byte arrays).
module tb_sysid_regfile;

    localparam logic [31:0] P_ID   = 32'h61936AD2;
    localparam logic [31:0] P_TS   = 32'h5F5E1000;
    localparam logic [31:0] P_VER  = 32'h01020003;
    localparam logic [31:0] P_FREQ = 32'd10;
    localparam int          P_NS   = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [3:0]  address = 4'd0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = 32'd0;
    logic [3:0]  byteenable = 4'd0;
    logic [31:0] readdata;
    logic        readdatavalid;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    longint unsigned m_cyc;
    longint unsigned m_active;   // prescaler-active cycles since last clear
    logic            m_freeze;
    logic [31:0]     m_snap;
    logic [31:0]     m_scr [8];
    logic [31:0]     exp_rd;
    logic            exp_vld;

    sysid_regfile #(
        .ID_VALUE(P_ID), .TIMESTAMP(P_TS), .VERSION(P_VER),
        .CLK_FREQ_HZ(P_FREQ), .NUM_SCRATCH(P_NS), .ADDR_W(4)
    ) dut (
        .clock(clock), .reset_n(reset_n), .address(address), .read(read),
        .write(write), .writedata(writedata), .byteenable(byteenable),
        .readdata(readdata), .readdatavalid(readdatavalid)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] ref_word(input logic [3:0] a);
        case (a)
            4'd0: return P_ID;
            4'd1: return P_TS;
            4'd2: return P_VER;
            4'd3: return P_FREQ;
            4'd4: return 32'(m_active / longint'(P_FREQ));
            4'd5: return m_cyc[31:0];
            4'd6: return m_snap;
            4'd7: return {30'd0, m_freeze, 1'b0};
            default: return (a >= 4'd8 && a < 4'(8 + P_NS)) ? m_scr[a - 4'd8] : 32'd0;
        endcase
    endfunction

    // Drive one bus cycle, advance the model across the edge, sample 1ns later
    task automatic step(input logic rn, input logic rd, input logic wr,
                        input logic [3:0] a, input logic [31:0] wd, input logic [3:0] be);
        logic ctrl;
        reset_n = rn; read = rd; write = wr; address = a; writedata = wd; byteenable = be;
        @(posedge clock);
        if (!rn) begin
            m_cyc = 0; m_active = 0; m_freeze = 1'b0; m_snap = 32'd0;
            for (int i = 0; i < 8; i++) m_scr[i] = 32'd0;
            exp_rd = 32'd0; exp_vld = 1'b0;
        end else begin
            exp_vld = rd;
            if (rd) exp_rd = ref_word(a);
            if (rd && a == 4'd5) m_snap = m_cyc[63:32];
            m_cyc = m_cyc + 1;
            ctrl = wr && a == 4'd7 && be[0];
            if (ctrl && wd[0]) m_active = 0;
            else if (!m_freeze) m_active = m_active + 1;
            if (ctrl) m_freeze = wd[1];
            if (wr && a >= 4'd8 && a < 4'(8 + P_NS))
                for (int b = 0; b < 4; b++)
                    if (be[b]) m_scr[a - 4'd8][8*b +: 8] = wd[8*b +: 8];
        end
        #1;
        reset_n = 1'b1; read = 1'b0; write = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
    endtask

    task automatic test_reset;
        logic [31:0] want [4];
        want[0] = 32'h61936AD2; want[1] = P_TS; want[2] = 32'h01020003; want[3] = 32'h0000000A;
        step(1'b0, 1'b1, 1'b0, 4'd0, 32'd0, 4'd0);
        n_tests++;
        if (readdata !== 32'd0 || readdatavalid !== 1'b0) begin
            n_fail++; $display("FAIL reset_state rd=%h vld=%b want 0/0", readdata, readdatavalid);
        end
        for (int a = 0; a < 4; a++) begin
            step(1'b1, 1'b1, 1'b0, 4'(a), 32'd0, 4'd0);
            n_tests++;
            if (readdata !== want[a] || readdatavalid !== 1'b1) begin
                n_fail++; $display("FAIL const_word%0d rd=%h vld=%b want %h/1", a, readdata, readdatavalid, want[a]);
            end
        end
        idle(1);
        n_tests++;
        if (readdatavalid !== 1'b0 || readdata !== want[3]) begin
            n_fail++; $display("FAIL rd_hold rd=%h vld=%b want %h/0", readdata, readdatavalid, want[3]);
        end
        step(1'b1, 1'b1, 1'b0, 4'd13, 32'd0, 4'd0);
        n_tests++;
        if (readdata !== 32'd0 || readdatavalid !== 1'b1) begin
            n_fail++; $display("FAIL unmapped rd=%h vld=%b want 0/1", readdata, readdatavalid);
        end
    endtask

    task automatic test_uptime_freeze;
        step(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
        idle(35);
        step(1'b1, 1'b1, 1'b0, 4'd4, 32'd0, 4'd0);
        n_tests++;
        if (readdata !== 32'd3) begin n_fail++; $display("FAIL uptime_35 rd=%0d want 3", readdata); end
        step(1'b1, 1'b0, 1'b1, 4'd7, 32'd2, 4'b0001);
        idle(50);
        step(1'b1, 1'b1, 1'b0, 4'd4, 32'd0, 4'd0);
        n_tests++;
        if (readdata !== 32'd3) begin n_fail++; $display("FAIL uptime_frozen rd=%0d want 3", readdata); end
        step(1'b1, 1'b1, 1'b0, 4'd7, 32'd0, 4'd0);
        n_tests++;
        if (readdata !== 32'd2) begin n_fail++; $display("FAIL ctrl_freeze rd=%h want 2", readdata); end
        step(1'b1, 1'b0, 1'b1, 4'd7, 32'd0, 4'b0001);
        idle(9);
        step(1'b1, 1'b1, 1'b0, 4'd4, 32'd0, 4'd0);
        n_tests++;
        if (readdata !== 32'd4 || readdata !== exp_rd) begin
            n_fail++; $display("FAIL uptime_thaw rd=%0d want 4 (model %0d)", readdata, exp_rd);
        end
    endtask

    task automatic test_clear;
        step(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
        idle(9);
        step(1'b1, 1'b0, 1'b1, 4'd7, 32'd1, 4'b0001);
        step(1'b1, 1'b1, 1'b0, 4'd4, 32'd0, 4'd0);
        n_tests++;
        if (readdata !== 32'd0) begin n_fail++; $display("FAIL clr_at_tc rd=%0d want 0", readdata); end
        idle(8);
        step(1'b1, 1'b1, 1'b0, 4'd4, 32'd0, 4'd0);
        n_tests++;
        if (readdata !== 32'd0) begin n_fail++; $display("FAIL clr_early rd=%0d want 0", readdata); end
        step(1'b1, 1'b1, 1'b0, 4'd4, 32'd0, 4'd0);
        n_tests++;
        if (readdata !== 32'd1) begin n_fail++; $display("FAIL clr_next_tick rd=%0d want 1", readdata); end
        step(1'b1, 1'b1, 1'b0, 4'd7, 32'd0, 4'd0);
        n_tests++;
        if (readdata !== 32'd0) begin n_fail++; $display("FAIL ctrl_rd0 rd=%h want 0", readdata); end
        // CTRL write with byte lane 0 disabled is ignored
        step(1'b1, 1'b0, 1'b1, 4'd7, 32'd3, 4'b1110);
        step(1'b1, 1'b1, 1'b0, 4'd7, 32'd0, 4'd0);
        n_tests++;
        if (readdata !== 32'd0) begin n_fail++; $display("FAIL ctrl_be0 rd=%h want 0", readdata); end
        // Clear and freeze together: cleared, then held
        idle(12);
        step(1'b1, 1'b0, 1'b1, 4'd7, 32'd3, 4'b0001);
        idle(25);
        step(1'b1, 1'b1, 1'b0, 4'd4, 32'd0, 4'd0);
        n_tests++;
        if (readdata !== 32'd0) begin n_fail++; $display("FAIL clr_freeze rd=%0d want 0", readdata); end
        step(1'b1, 1'b0, 1'b1, 4'd7, 32'd0, 4'b0001);
    endtask

    task automatic test_cycle_snapshot;
        force dut.cyc_q = 64'h0000_0001_FFFF_FFFE;
        m_cyc = 64'h0000_0001_FFFF_FFFE;
        step(1'b1, 1'b1, 1'b0, 4'd5, 32'd0, 4'd0);
        release dut.cyc_q;
        n_tests++;
        if (readdata !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL cyc_lo rd=%h want FFFFFFFE", readdata); end
        idle(4);
        step(1'b1, 1'b1, 1'b0, 4'd6, 32'd0, 4'd0);
        n_tests++;
        if (readdata !== 32'h00000001) begin n_fail++; $display("FAIL cyc_hi_snap rd=%h want 00000001", readdata); end
        // Fresh reset: counter increments and snapshot follow elapsed cycles
        step(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
        idle(7);
        step(1'b1, 1'b1, 1'b0, 4'd5, 32'd0, 4'd0);
        n_tests++;
        if (readdata !== 32'd7) begin n_fail++; $display("FAIL cyc_count rd=%0d want 7", readdata); end
    endtask

    task automatic test_scratch;
        logic [31:0] v;
        step(1'b1, 1'b0, 1'b1, 4'd8, 32'hAABBCCDD, 4'b1111);
        step(1'b1, 1'b0, 1'b1, 4'd8, 32'h11223344, 4'b0101);
        step(1'b1, 1'b1, 1'b0, 4'd8, 32'd0, 4'd0);
        n_tests++;
        if (readdata !== 32'hAA22CC44) begin n_fail++; $display("FAIL scratch_be rd=%h want AA22CC44", readdata); end
        step(1'b1, 1'b0, 1'b1, 4'd1, 32'hFFFFFFFF, 4'b1111);
        step(1'b1, 1'b1, 1'b0, 4'd1, 32'd0, 4'd0);
        n_tests++;
        if (readdata !== P_TS) begin n_fail++; $display("FAIL ro_write rd=%h want %h", readdata, P_TS); end
        v = $urandom;
        step(1'b1, 1'b0, 1'b1, 4'd9, v, 4'b1111);
        step(1'b1, 1'b1, 1'b1, 4'd9, ~v, 4'b1111);
        n_tests++;
        if (readdata !== v) begin n_fail++; $display("FAIL rw_old rd=%h want %h", readdata, v); end
        step(1'b1, 1'b1, 1'b0, 4'd9, 32'd0, 4'd0);
        n_tests++;
        if (readdata !== ~v) begin n_fail++; $display("FAIL rw_new rd=%h want %h", readdata, ~v); end
        for (int i = 0; i < 24; i++) begin
            logic [3:0] a;
            a = 4'(8 + $urandom_range(0, P_NS - 1));
            step(1'b1, 1'b0, 1'b1, a, $urandom, 4'($urandom));
            a = 4'(8 + $urandom_range(0, P_NS - 1));
            step(1'b1, 1'b1, 1'b0, a, 32'd0, 4'd0);
            n_tests++;
            if (readdata !== exp_rd) begin n_fail++; $display("FAIL scratch_rand a=%0d rd=%h want %h", a, readdata, exp_rd); end
        end
    endtask

    task automatic test_reset_midread;
        step(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
        step(1'b1, 1'b0, 1'b1, 4'd10, 32'h12345678, 4'b1111);
        idle(54);
        step(1'b1, 1'b1, 1'b0, 4'd4, 32'd0, 4'd0);
        n_tests++;
        if (readdata !== 32'd5) begin n_fail++; $display("FAIL pre_reset_uptime rd=%0d want 5", readdata); end
        step(1'b0, 1'b1, 1'b0, 4'd10, 32'd0, 4'd0);
        n_tests++;
        if (readdatavalid !== 1'b0 || readdata !== 32'd0) begin
            n_fail++; $display("FAIL reset_read rd=%h vld=%b want 0/0", readdata, readdatavalid);
        end
        step(1'b1, 1'b1, 1'b0, 4'd4, 32'd0, 4'd0);
        n_tests++;
        if (readdata !== 32'd0) begin n_fail++; $display("FAIL reset_uptime rd=%0d want 0", readdata); end
        step(1'b1, 1'b1, 1'b0, 4'd10, 32'd0, 4'd0);
        n_tests++;
        if (readdata !== 32'd0) begin n_fail++; $display("FAIL reset_scratch rd=%h want 0", readdata); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            logic rd, wr;
            logic [3:0] a;
            rd = 1'($urandom);
            wr = ($urandom_range(0, 3) == 0);
            a  = 4'($urandom);
            step(1'b1, rd, wr, a, $urandom, 4'($urandom));
            n_tests++;
            if (readdatavalid !== exp_vld || readdata !== exp_rd) begin
                n_fail++;
                $display("FAIL random i=%0d a=%0d rd=%h vld=%b want %h/%b", i, a, readdata, readdatavalid, exp_rd, exp_vld);
            end
        end
    endtask

    initial begin
        m_cyc = 0; m_active = 0; m_freeze = 1'b0; m_snap = 32'd0;
        exp_rd = 32'd0; exp_vld = 1'b0;
        for (int i = 0; i < 8; i++) m_scr[i] = 32'd0;
        test_reset();
        test_uptime_freeze();
        test_clear();
        test_cycle_snapshot();
        test_scratch();
        test_reset_midread();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
